// File: rtl/aes_sched_pkg.sv
// Shared constants and state encoding for the AES coprocessor scheduler.
package aes_sched_pkg;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned NUM_REQ = 2;
    localparam logic        REQ_ID0 = 1'b0;
    localparam logic        REQ_ID1 = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other side on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    // ptr_q names the requester holding priority on contention.
    logic ptr_q;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= grant[0];
        end
    end
endmodule

// File: rtl/aes_cop_sched.sv
// Schedules two requesters onto separate AES enc/dec cores with a shared key register.
// Optional WAIT timeout is built when AES_SCHED_TIMEOUT_EN is defined.
module aes_cop_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_wr,
    input  logic [BLOCK_W-1:0]   key_in,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_decrypt,
    input  logic [2*BLOCK_W-1:0] req_data,
    output logic                 aes_start_enc,
    output logic                 aes_start_dec,
    output logic [BLOCK_W-1:0]   aes_key,
    output logic [BLOCK_W-1:0]   aes_data,
    input  logic                 enc_valid,
    input  logic                 dec_valid,
    input  logic [BLOCK_W-1:0]   enc_res,
    input  logic [BLOCK_W-1:0]   dec_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [BLOCK_W-1:0]   rsp_data,
    output logic                 rsp_timeout,
    output logic                 busy
);
    if ((64'(1) << CNT_BITS) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_bits
        $error("CNT_BITS too narrow for TIMEOUT_CYCLES");
    end

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] key_q, op_key_q, data_q, rsp_data_q;
    logic               dec_q, id_q;
    logic [1:0]         grant;
    logic               accept, sel_valid, tmo_hit;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        req_ready = 2'b00;
        if (state_q == StIdle && !reset) begin
            req_ready = grant;
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign sel_valid = dec_q ? dec_valid : enc_valid;

`ifdef AES_SCHED_TIMEOUT_EN
    logic [CNT_BITS-1:0] cnt_q;
    logic                timeout_q;

    assign tmo_hit = (state_q == StWait) && (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == StWait) ? cnt_q + 1'b1 : '0;
            // A result in the timeout cycle takes precedence.
            if (state_q == StWait) begin
                if (sel_valid) begin
                    timeout_q <= 1'b0;
                end else if (tmo_hit) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (sel_valid || tmo_hit) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            key_q      <= '0;
            op_key_q   <= '0;
            data_q     <= '0;
            dec_q      <= 1'b0;
            id_q       <= REQ_ID0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && key_wr) begin
                key_q <= key_in;
            end
            // Snapshot the pre-update key so a coincident key_wr does not affect this request.
            if (accept) begin
                op_key_q <= key_q;
                data_q   <= req_ready[1] ? req_data[2*BLOCK_W-1:BLOCK_W] : req_data[BLOCK_W-1:0];
                dec_q    <= req_ready[1] ? req_decrypt[1] : req_decrypt[0];
                id_q     <= req_ready[1] ? REQ_ID1 : REQ_ID0;
            end
            if (state_q == StWait) begin
                if (sel_valid) begin
                    rsp_data_q <= dec_q ? dec_res : enc_res;
                end else if (tmo_hit) begin
                    rsp_data_q <= '0;
                end
            end
        end
    end

    assign aes_start_enc = (state_q == StIssue) && !dec_q && !reset;
    assign aes_start_dec = (state_q == StIssue) && dec_q && !reset;
    assign aes_key       = op_key_q;
    assign aes_data      = data_q;
    assign rsp_valid     = (state_q == StResp);
    assign rsp_id        = id_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_aes_cop_sched.sv
// Directed self-checking bench for aes_cop_sched; the bench plays both AES cores.
module tb_aes_cop_sched;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] PT2  = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk = 1'b0;
    logic         reset, key_wr, enc_valid, dec_valid, rsp_ready;
    logic [127:0] key_in, enc_res, dec_res;
    logic [1:0]   req_valid, req_decrypt, req_ready;
    logic [255:0] req_data;
    logic         aes_start_enc, aes_start_dec, rsp_valid, rsp_id, rsp_timeout, busy;
    logic [127:0] aes_key, aes_data, rsp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aes_cop_sched #(.TIMEOUT_CYCLES(16), .CNT_BITS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_wr        (key_wr),
        .key_in        (key_in),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_decrypt   (req_decrypt),
        .req_data      (req_data),
        .aes_start_enc (aes_start_enc),
        .aes_start_dec (aes_start_dec),
        .aes_key       (aes_key),
        .aes_data      (aes_data),
        .enc_valid     (enc_valid),
        .dec_valid     (dec_valid),
        .enc_res       (enc_res),
        .dec_res       (dec_res),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one request through handshake, core emulation and response; reports observations.
    task automatic run_txn(input logic [1:0] valid, input logic [1:0] dec, input logic [255:0] data,
                           input logic [127:0] res, input logic hold, input logic kw,
                           input logic [127:0] kin, output logic [1:0] gnt,
                           output logic [127:0] key_seen, output logic [127:0] data_seen,
                           output logic [127:0] rsp, output logic rid, output int enc_p,
                           output int dec_p, output int lat, output logic multi, output logic ok);
        logic got, sel_dec;
        got = 1'b0; ok = 1'b1; multi = 1'b0; enc_p = 0; dec_p = 0; lat = 0; gnt = 2'b00;
        key_seen = '0; data_seen = '0; rsp = '0; rid = 1'b0; sel_dec = 1'b0;
        req_valid = valid; req_decrypt = dec; req_data = data; key_wr = kw; key_in = kin;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (req_ready == 2'b11) multi = 1'b1;
            if ((req_ready & req_valid) != 2'b00) begin
                got = 1'b1;
                gnt = req_ready;
            end
            tick();
            key_wr = 1'b0;
        end
        if (!hold) req_valid = 2'b00;
        if (!got) begin
            ok = 1'b0;
        end else begin
            enc_p += int'(aes_start_enc);
            dec_p += int'(aes_start_dec);
            key_seen  = aes_key;
            data_seen = aes_data;
            sel_dec   = aes_start_dec;
            if (!(aes_start_enc ^ aes_start_dec)) ok = 1'b0;
            tick();
            lat = 2;
            enc_p += int'(aes_start_enc);
            dec_p += int'(aes_start_dec);
            if (sel_dec) begin
                dec_valid = 1'b1; dec_res = res;
            end else begin
                enc_valid = 1'b1; enc_res = res;
            end
            tick();
            lat = 3;
            enc_valid = 1'b0; dec_valid = 1'b0;
            for (int i = 0; i < 8 && !rsp_valid; i++) begin
                tick();
                lat++;
            end
            enc_p += int'(aes_start_enc);
            dec_p += int'(aes_start_dec);
            if (!rsp_valid) ok = 1'b0;
            rsp = rsp_data;
            rid = rsp_id;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 2'b11;
        tick(); tick();
        tests++;
        if ({req_ready, aes_start_enc, aes_start_dec, rsp_valid, rsp_timeout, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {req_ready, aes_start_enc, aes_start_dec, rsp_valid, rsp_timeout, busy});
        end
        tests++;
        if (rsp_data !== '0 || aes_key !== '0) begin
            fails++; $display("FAIL reset_regs rsp_data=%h aes_key=%h exp=0", rsp_data, aes_key);
        end
        reset = 1'b0; req_valid = 2'b00; #1;
        tests++;
        if (req_ready !== 2'b00) begin
            fails++; $display("FAIL ready_no_valid got=%b exp=00", req_ready);
        end
        req_valid = 2'b10; #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++; $display("FAIL ready_single1 got=%b exp=10", req_ready);
        end
        req_valid = 2'b11; #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL ready_prio_after_reset got=%b exp=01", req_ready);
        end
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11; #1;
        tests++;
        if (busy !== 1'b0 || req_ready !== 2'b01) begin
            fails++; $display("FAIL cancel_no_effect busy=%b ready=%b exp busy=0 ready=01", busy, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_encrypt;
        key_wr = 1'b1; key_in = KEY;
        tick();
        key_wr = 1'b0;
        req_valid = 2'b01; req_decrypt = 2'b00; req_data = {128'h0, PT}; #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL enc_ready got=%b exp=01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tests++;
        if ({aes_start_enc, aes_start_dec, busy, req_ready} !== 5'b10100) begin
            fails++; $display("FAIL enc_issue got=%b exp=10100",
                              {aes_start_enc, aes_start_dec, busy, req_ready});
        end
        tests++;
        if (aes_key !== KEY || aes_data !== PT) begin
            fails++; $display("FAIL enc_operands key=%h data=%h exp %h %h", aes_key, aes_data, KEY, PT);
        end
        tick();
        tests++;
        if (aes_start_enc !== 1'b0 || rsp_valid !== 1'b0 || aes_key !== KEY) begin
            fails++; $display("FAIL enc_wait start=%b rsp_valid=%b key=%h exp 0 0 %h",
                              aes_start_enc, rsp_valid, aes_key, KEY);
        end
        enc_valid = 1'b1; enc_res = CT;
        tick();
        enc_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== CT || rsp_id !== 1'b0 || rsp_timeout !== 1'b0) begin
            fails++; $display("FAIL enc_resp valid=%b data=%h id=%b tmo=%b exp 1 %h 0 0",
                              rsp_valid, rsp_data, rsp_id, rsp_timeout, CT);
        end
        req_valid = 2'b01; rsp_ready = 1'b1; #1;
        tests++;
        if (req_ready !== 2'b00) begin
            fails++; $display("FAIL no_accept_on_resp_exit got=%b exp=00", req_ready);
        end
        tick();
        rsp_ready = 1'b0; #1;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b01) begin
            fails++; $display("FAIL back_to_idle valid=%b busy=%b ready=%b exp 0 0 01",
                              rsp_valid, busy, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_decrypt;
        logic [1:0] g; logic [127:0] ks, ds, r; logic id, m, ok; int ep, dp, lat;
        req_valid = 2'b11; #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++; $display("FAIL rr_prio_after_grant0 got=%b exp=10", req_ready);
        end
        run_txn(2'b10, 2'b10, {CT, 128'h0}, PT, 1'b0, 1'b0, '0, g, ks, ds, r, id, ep, dp, lat, m, ok);
        tests++;
        if (!ok || g !== 2'b10 || id !== 1'b1 || r !== PT) begin
            fails++; $display("FAIL dec_result ok=%b gnt=%b id=%b data=%h exp 1 10 1 %h", ok, g, id, r, PT);
        end
        tests++;
        if (ep != 0 || dp != 1) begin
            fails++; $display("FAIL dec_pulses enc=%0d dec=%0d exp 0 1", ep, dp);
        end
        tests++;
        if (ks !== KEY || ds !== CT || lat != 3) begin
            fails++; $display("FAIL dec_operands key=%h data=%h lat=%0d exp %h %h 3", ks, ds, lat, KEY, CT);
        end
    endtask

    task automatic test_resp_hold_key;
        logic [1:0] g; logic [127:0] ks, ds, r; logic id, m, ok, bad; int ep, dp, lat;
        req_valid = 2'b01; req_decrypt = 2'b00; req_data = {128'h0, PT};
        tick();
        req_valid = 2'b00;
        tick();
        key_wr = 1'b1; key_in = ONES;
        tick();
        key_wr = 1'b0;
        tests++;
        if (aes_key !== KEY || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL key_wr_in_wait key=%h rsp_valid=%b exp %h 0", aes_key, rsp_valid, KEY);
        end
        enc_valid = 1'b1; enc_res = CT;
        tick();
        enc_valid = 1'b0; req_valid = 2'b11; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_data !== CT || rsp_id !== 1'b0 || req_ready !== 2'b00)
                bad = 1'b1;
            tick();
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++; $display("FAIL resp_hold_stable got=%b exp=0", bad);
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        run_txn(2'b01, 2'b00, {128'h0, PT}, CT, 1'b0, 1'b0, '0, g, ks, ds, r, id, ep, dp, lat, m, ok);
        tests++;
        if (!ok || ks !== KEY || r !== CT || ep != 1 || dp != 0) begin
            fails++; $display("FAIL old_key_used ok=%b key=%h rsp=%h enc=%0d dec=%0d exp 1 %h %h 1 0",
                              ok, ks, r, ep, dp, KEY, CT);
        end
    endtask

    task automatic test_key_coincident;
        logic [1:0] g; logic [127:0] ks, ds, r; logic id, m, ok; int ep, dp, lat;
        run_txn(2'b01, 2'b00, {128'h0, PT}, CT, 1'b0, 1'b1, ONES, g, ks, ds, r, id, ep, dp, lat, m, ok);
        tests++;
        if (!ok || ks !== KEY) begin
            fails++; $display("FAIL coincident_key_old ok=%b key=%h exp 1 %h", ok, ks, KEY);
        end
        run_txn(2'b01, 2'b00, {128'h0, PT}, CT, 1'b0, 1'b0, '0, g, ks, ds, r, id, ep, dp, lat, m, ok);
        tests++;
        if (!ok || ks !== ONES) begin
            fails++; $display("FAIL coincident_key_new ok=%b key=%h exp 1 %h", ok, ks, ONES);
        end
    endtask

    task automatic test_wait;
        int n;
        logic bad;
        req_valid = 2'b01; req_decrypt = 2'b00; req_data = {128'h0, PT};
        tick();
        req_valid = 2'b00;
        tick();
        dec_valid = 1'b1; dec_res = ONES;
`ifdef AES_SCHED_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        dec_valid = 1'b0;
        tests++;
        if (n != 16) begin
            fails++; $display("FAIL timeout_cycles got=%0d exp=16", n);
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== '0) begin
            fails++; $display("FAIL timeout_resp valid=%b tmo=%b data=%h exp 1 1 0",
                              rsp_valid, rsp_timeout, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        for (int i = 0; i < 15; i++) tick();
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_early got=%b exp=0", rsp_valid);
        end
        enc_valid = 1'b1; enc_res = CT;
        tick();
        enc_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_data !== CT) begin
            fails++; $display("FAIL result_beats_timeout valid=%b tmo=%b data=%h exp 1 0 %h",
                              rsp_valid, rsp_timeout, rsp_data, CT);
        end
`else
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            tick();
        end
        dec_valid = 1'b0;
        tests++;
        if (bad !== 1'b0) begin
            fails++; $display("FAIL wait_indefinite got=%b exp=0", bad);
        end
        enc_valid = 1'b1; enc_res = CT;
        tick();
        enc_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_data !== CT) begin
            fails++; $display("FAIL late_result valid=%b tmo=%b data=%h exp 1 0 %h",
                              rsp_valid, rsp_timeout, rsp_data, CT);
        end
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] g, exp_g; logic [127:0] ks, ds, r, exp_d; logic id, m, ok; int ep, dp, lat;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? PT : PT2;
            run_txn(2'b11, 2'b00, {PT2, PT}, CT, 1'b1, 1'b0, '0, g, ks, ds, r, id, ep, dp, lat, m, ok);
            tests++;
            if (!ok || g !== exp_g || m !== 1'b0 || ds !== exp_d || id !== exp_g[1]) begin
                fails++; $display("FAIL b2b_txn%0d ok=%b gnt=%b multi=%b data=%h id=%b exp 1 %b 0 %h %b",
                                  k, ok, g, m, ds, id, exp_g, exp_d, exp_g[1]);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid;
        logic [1:0] g; logic [127:0] ks, ds, r; logic id, m, ok; int ep, dp, lat;
        req_valid = 2'b01; req_decrypt = 2'b00; req_data = {128'h0, PT};
        tick();
        req_valid = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; enc_valid = 1'b1; enc_res = CT;
        tick();
        enc_valid = 1'b0;
        tick();
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_mid_abandon valid=%b busy=%b exp 0 0", rsp_valid, busy);
        end
        run_txn(2'b11, 2'b00, {PT2, PT}, CT, 1'b0, 1'b0, '0, g, ks, ds, r, id, ep, dp, lat, m, ok);
        tests++;
        if (!ok || g !== 2'b01 || ks !== '0 || r !== CT || lat != 3) begin
            fails++; $display("FAIL after_reset_txn ok=%b gnt=%b key=%h rsp=%h lat=%0d exp 1 01 0 %h 3",
                              ok, g, ks, r, lat, CT);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_wr = 1'b0; key_in = '0; req_valid = 2'b00; req_decrypt = 2'b00;
        req_data = '0; enc_valid = 1'b0; dec_valid = 1'b0; enc_res = '0; dec_res = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_resp_hold_key();
        test_key_coincident();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
